// File: rtl/aes_key_expand.sv
// AES-128 key schedule, one round key per next request.
// Byte-serial SubWord through a single shared S-box.
module aes_key_expand #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [word_size*array_size-1:0] key_in,
    input  logic                            next,
    output logic [word_size*array_size-1:0] round_key,
    output logic [3:0]                      round_idx,
    output logic                            key_valid,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {IDLE, HOLD, SUB, MIX} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t      state;
    state_t      state_d;
    logic [1:0]  bc;
    logic [31:0] temp;
    logic [7:0]  sb_in;
    logic [7:0]  sb_out;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t, n0, n1, n2, n3;
    logic        accept;

    // Byte 0 of the table sits in the top bits.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] p;
        p = {~x, 3'b000};
        return SBOX[p +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        unique case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign accept = (state == HOLD) && next && (round_idx != 4'd10);

    // Pick the RotWord(w3) byte for the current SubWord step.
    always_comb begin
        sb_in = w3[23:16];
        unique case (bc)
            2'd0: sb_in = w3[23:16];
            2'd1: sb_in = w3[15:8];
            2'd2: sb_in = w3[7:0];
            2'd3: sb_in = w3[31:24];
        endcase
    end

    assign sb_out = sbox(sb_in);

    assign t  = temp ^ {rcon(round_idx + 4'd1), 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state; start wins over everything, aborting work.
    always_comb begin
        state_d = state;
        priority case (1'b1)
            start:                         state_d = HOLD;
            accept:                        state_d = SUB;
            (state == SUB && bc == 2'd3):  state_d = MIX;
            (state == MIX):                state_d = HOLD;
            default:                       state_d = state;
        endcase
    end

    // Round key, index, byte counter and SubWord temp.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_key <= '0;
            round_idx <= 4'd0;
            bc        <= 2'd0;
            temp      <= 32'h0;
        end else if (start) begin
            round_key <= key_in;
            round_idx <= 4'd0;
            bc        <= 2'd0;
            temp      <= 32'h0;
        end else begin
            unique case (state)
                HOLD: if (accept) bc <= 2'd0;
                SUB: begin
                    unique case (bc)
                        2'd0: temp[31:24] <= sb_out;
                        2'd1: temp[23:16] <= sb_out;
                        2'd2: temp[15:8]  <= sb_out;
                        2'd3: temp[7:0]   <= sb_out;
                    endcase
                    bc <= bc + 2'd1;
                end
                MIX: begin
                    round_key <= {n0, n1, n2, n3};
                    round_idx <= round_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Status decoded from the registered state.
    always_comb begin
        key_valid = (state == HOLD);
        busy      = (state == SUB) || (state == MIX);
        done      = (state == HOLD) && (round_idx == 4'd10);
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: scoreboard plus a
// GF(2^8)-derived reference key schedule.
module tb_aes_key_expand;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         next = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int           tests = 0;
    int           fails = 0;
    exp_t         sb[$];
    logic [127:0] mkey;
    int           midx;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3)
                 ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = xt(c);
        return c;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
        logic [31:0] w[4];
        logic [31:0] rw, sw, tt;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rw = {w[3][23:0], w[3][31:24]};
        for (int i = 0; i < 4; i++)
            sw[31-8*i -: 8] = sbox_ref(rw[31-8*i -: 8]);
        tt = sw ^ {rcon_ref(r), 24'h0};
        w[0] = w[0] ^ tt;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation each time a new key is presented.
    task automatic monitor();
        logic         pv = 1'b0;
        logic [127:0] pk = '0;
        logic [3:0]   pi = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1 &&
                (!pv || round_key !== pk || round_idx !== pi)) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_unexpected: got key %h idx %0d, expected none",
                             round_key, round_idx);
                end else begin
                    e = sb.pop_front();
                    chk("mon_key", round_key, e.key);
                    chk("mon_idx", 128'(round_idx), 128'(e.idx));
                    chk("mon_done", 128'(done), 128'(e.idx == 4'd10));
                end
            end
            pv = key_valid;
            pk = round_key;
            pi = round_idx;
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        mkey   = k;
        midx   = 0;
        sb.push_back({k, 4'd0});
        step();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("start_valid", 128'(key_valid), 128'(1));
        chk("start_idx", 128'(round_idx), 128'(0));
    endtask

    task automatic do_next();
        int n = 0;
        next = 1'b1;
        if (midx < 10) begin
            midx++;
            mkey = next_key(mkey, midx);
            sb.push_back({mkey, 4'(midx)});
        end
        step();
        next = 1'b0;
        while (!key_valid && n < 20) begin
            step();
            n++;
        end
        chk("next_latency", 128'(n), 128'(key_valid && sb.size() == 0 && round_idx == 4'd10 && n == 0 ? 0 : 5));
    endtask

    initial begin
        logic [127:0] hold_key;
        fork
            monitor();
        join_none

        // Reset, including rst overriding start.
        repeat (2) step();
        start = 1'b1;
        key_in = 128'h1;
        step();
        start = 1'b0;
        chk("rst_key", round_key, 128'h0);
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_valid", 128'(key_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        step();

        // FIPS-197 A.1 first round, with a stray next during SUB.
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips_k0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        next = 1'b1;
        midx = 1;
        mkey = next_key(mkey, 1);
        sb.push_back({mkey, 4'd1});
        step();
        next = 1'b0;
        chk("sub_valid", 128'(key_valid), 128'(0));
        chk("sub_busy", 128'(busy), 128'(1));
        for (int i = 0; i < 4; i++) begin
            next = (i == 1);
            key_in = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("sub_key_hold", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            chk("sub_wait_valid", 128'(key_valid), 128'(0));
        end
        next = 1'b0;
        step();
        chk("fips_k1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_idx1", 128'(round_idx), 128'(1));
        chk("fips_idle", 128'(busy), 128'(0));

        // Full schedule with next held high.
        next = 1'b1;
        for (int r = 2; r <= 10; r++) begin
            midx = r;
            mkey = next_key(mkey, r);
            sb.push_back({mkey, 4'(r)});
            repeat (6) step();
            chk("sched_idx", 128'(round_idx), 128'(r));
            chk("sched_valid", 128'(key_valid), 128'(1));
        end
        chk("fips_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_done", 128'(done), 128'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("r10_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            chk("r10_idx", 128'(round_idx), 128'(10));
            chk("r10_busy", 128'(busy), 128'(0));
        end
        next = 1'b0;
        step();

        // Abort with start at SUB bc=2.
        start_key({$urandom, $urandom, $urandom, $urandom});
        do_next();
        next = 1'b1;
        step();
        next = 1'b0;
        repeat (2) step();
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        start = 1'b1;
        mkey = key_in;
        midx = 0;
        sb.push_back({mkey, 4'd0});
        step();
        start = 1'b0;
        chk("abort_key", round_key, 128'h000102030405060708090a0b0c0d0e0f);
        chk("abort_idx", 128'(round_idx), 128'(0));
        chk("abort_valid", 128'(key_valid), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        do_next();
        chk("abort_k1", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        // Reset during MIX.
        start_key({$urandom, $urandom, $urandom, $urandom});
        next = 1'b1;
        step();
        next = 1'b0;
        repeat (4) step();
        chk("mix_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_key", round_key, 128'h0);
        chk("mrst_idx", 128'(round_idx), 128'(0));
        chk("mrst_valid", 128'(key_valid), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        chk("mrst_done", 128'(done), 128'(0));
        for (int i = 0; i < 3; i++) begin
            next = 1'b1;
            step();
            next = 1'b0;
            step();
            chk("mrst_next_ign", 128'({key_valid, busy, round_idx}), 128'(0));
        end

        // Simultaneous start+next at round 3.
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (3) do_next();
        hold_key = {$urandom, $urandom, $urandom, $urandom};
        key_in = hold_key;
        start = 1'b1;
        next = 1'b1;
        mkey = hold_key;
        midx = 0;
        sb.push_back({hold_key, 4'd0});
        step();
        start = 1'b0;
        next = 1'b0;
        chk("sim_key", round_key, hold_key);
        chk("sim_idx", 128'(round_idx), 128'(0));
        chk("sim_busy", 128'(busy), 128'(0));
        step();
        chk("sim_still_busy", 128'(busy), 128'(0));
        chk("sim_still_idx", 128'(round_idx), 128'(0));

        // Random keys and random request counts.
        for (int k = 0; k < 4; k++) begin
            start_key({$urandom, $urandom, $urandom, $urandom});
            for (int j = 0; j < int'($urandom_range(1, 11)); j++) begin
                repeat ($urandom_range(0, 3)) step();
                do_next();
            end
        end

        repeat (3) step();
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
